// File: rtl/stream_mux_arb_if.sv
// Handshake bundle between N producers, the stream_mux_arb and its single consumer.
// The slave modport is the view of the multiplexer itself; master is the surrounding fabric.
interface stream_mux_arb_if #(
   parameter int unsigned NUM_IN = 32,
   parameter int unsigned WIDTH  = 2,
   parameter int unsigned SEL_W  = 5
);
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_chan;
   logic                    out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_chan
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_chan
   );
endinterface

// File: rtl/stream_mux_arb.sv
// Registered N:1 stream multiplexer. One grant per cycle chosen by explicit select,
// fixed priority or round-robin; the winner's data and index land in a single-entry
// output register that is reloaded whenever it is empty or being drained.
module stream_mux_arb #(
   parameter int unsigned NUM_IN = 32,
   parameter int unsigned WIDTH  = 2,
   parameter int unsigned SEL_W  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [SEL_W-1:0] sel,
   output logic             sel_err,
   stream_mux_arb_if.slave  bus
);
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_chan_q, out_chan_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             sel_err_q, sel_err_d;

   logic             load_en;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [WIDTH-1:0] grant_data;
   int unsigned      rr_idx;

   assign load_en = !out_valid_q || bus.out_ready;

   // Grant decision for the current cycle; later loop iterations win, so loops run
   // from the least to the most preferred candidate.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_idx    = 0;
      case (mode)
         2'd0: begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
               if (sel == SEL_W'(i) && bus.in_valid[i]) begin
                  grant_vld = 1'b1;
                  grant_idx = SEL_W'(i);
               end
            end
         end
         2'd1: begin
            for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
               if (bus.in_valid[i]) begin
                  grant_vld = 1'b1;
                  grant_idx = SEL_W'(i);
               end
            end
         end
         2'd2: begin
            // Scan offsets from rr_ptr, wrapping at NUM_IN rather than 2^SEL_W.
            for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
               rr_idx = 32'(rr_ptr_q) + 32'(k);
               if (rr_idx >= NUM_IN) rr_idx = rr_idx - NUM_IN;
               if (bus.in_valid[rr_idx]) begin
                  grant_vld = 1'b1;
                  grant_idx = SEL_W'(rr_idx);
               end
            end
         end
         default: ;
      endcase
   end

   // Data mux for the granted channel and the one-hot ready back to it.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < int'(NUM_IN); i++) begin
         bus.in_ready[i] = !reset && load_en && grant_vld && (grant_idx == SEL_W'(i));
         if (grant_idx == SEL_W'(i)) grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   // Next state of the output register, round-robin pointer and select-error pulse.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      rr_ptr_d    = rr_ptr_q;
      sel_err_d   = 1'b0;
      if (load_en) begin
         out_valid_d = grant_vld;
         sel_err_d   = (mode == 2'd0) && (32'(sel) >= NUM_IN);
         if (grant_vld) begin
            out_data_d = grant_data;
            out_chan_d = grant_idx;
            if (mode == 2'd2) begin
               rr_ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
         end
      end
   end

   // State registers with synchronous reset; reset drops any held word.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         rr_ptr_q    <= '0;
         sel_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         rr_ptr_q    <= rr_ptr_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;
   assign sel_err       = sel_err_q;
endmodule
